cu_sequencer: RTL
=================

CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 The block SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-002 The ports SHALL be as follows, clock and reset first:
- CLK  in  1  system clock, all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- OPCODE  in  7  instruction bits [6:0]
- FUNC3  in  3  instruction bits [14:12]
- INTR  in  1  interrupt request, already gated by MIE
- MEM_READY  in  1  instruction memory data valid
- PC_WE  out  1  program counter write enable
- RF_WE  out  1  register file write enable
- MEM_RDEN1  out  1  instruction fetch read enable
- MEM_RDEN2  out  1  data memory read enable
- MEM_WE2  out  1  data memory write enable
- CSR_WE  out  1  CSR write enable
- INT_TAKEN  out  1  interrupt entry strobe
- MRET_EXEC  out  1  mret strobe
- ILLEGAL  out  1  unrecognised opcode strobe
- INSTRET  out  32  retired-instruction count

Function
REQ-003 The states SHALL be INIT, FETCH, EXEC, WB and INTR, held in a registered state variable.
REQ-004 The strobe outputs (PC_WE through ILLEGAL) SHALL be combinational in the current state, OPCODE and FUNC3, and SHALL be 0 unless this section sets them.
REQ-005 INIT SHALL assert no output and SHALL go to FETCH unconditionally on the next edge.
REQ-006 FETCH SHALL assert MEM_RDEN1, SHALL stay in FETCH while MEM_READY=0 and SHALL go to EXEC on the edge where MEM_READY=1.
REQ-007 In EXEC, for LOAD (0000011), the block SHALL assert MEM_RDEN2 only, with PC_WE=0, and SHALL go to WB next.
REQ-008 In EXEC, for STORE (0100011), the block SHALL assert MEM_WE2 and PC_WE.
REQ-009 In EXEC, for BRANCH (1100011), the block SHALL assert PC_WE only.
REQ-010 In EXEC, for LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111), OP-IMM (0010011) and OP (0110011), the block SHALL assert PC_WE and RF_WE.
REQ-011 In EXEC, for SYSTEM (1110011) with FUNC3=000 (mret), the block SHALL assert PC_WE and MRET_EXEC.
REQ-012 In EXEC, for SYSTEM with FUNC3 in {001,010,011}, the block SHALL assert PC_WE, RF_WE and CSR_WE; any other SYSTEM FUNC3 SHALL be handled as illegal.
REQ-013 In EXEC, for any other opcode, the block SHALL assert PC_WE and ILLEGAL with no RF or memory writes.
REQ-014 WB SHALL assert RF_WE and PC_WE.
REQ-015 When leaving EXEC with a non-LOAD opcode, or when leaving WB, the next state SHALL be INTR if INTR=1 at that edge, otherwise FETCH.
REQ-016 INTR SHALL be sampled only at EXEC or WB exit; INTR asserted during FETCH, INIT or INTR SHALL be ignored until the next EXEC/WB exit.
REQ-017 INTR state SHALL assert INT_TAKEN and PC_WE for exactly one cycle, then go to FETCH regardless of INTR.
REQ-018 INSTRET SHALL increment by 1 on each edge leaving EXEC with a non-LOAD opcode (illegal included) and on each edge leaving WB; it SHALL NOT increment in INTR.
REQ-019 INSTRET SHALL wrap from 0xFFFFFFFF to 0x00000000 with no flag.
REQ-020 Fetch latency SHALL be 1 cycle plus the number of MEM_READY=0 cycles; a non-load instruction SHALL take 2 cycles minimum and a load 3.

Reset
REQ-021 RST_N=0 SHALL immediately force state to INIT and INSTRET to 0, so that all strobes read 0 without waiting for a clock edge.
REQ-022 Reset asserted mid-instruction (including in WB or INTR) SHALL abort the instruction with no further strobes; INSTRET SHALL NOT count the aborted instruction.
REQ-023 After RST_N rises, the first FETCH SHALL occur on the second rising edge (INIT, then FETCH).

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset release, MEM_READY=1, OPCODE=0110011: the sequence SHALL be INIT, FETCH, EXEC; PC_WE=RF_WE=1 in EXEC; INSTRET=1 after the EXEC edge.
- LOAD with MEM_READY low for 3 cycles: FETCH SHALL last 4 cycles; MEM_RDEN2=1 with PC_WE=0 in EXEC; RF_WE=PC_WE=1 in WB; INSTRET increments once.
- STORE with INTR=1 at EXEC exit: MEM_WE2=1 in EXEC, then INTR with INT_TAKEN=1 for 1 cycle, then FETCH; INSTRET +1 only.
- SYSTEM FUNC3=000: MRET_EXEC=1 and PC_WE=1, RF_WE=0. SYSTEM FUNC3=001: CSR_WE=RF_WE=1. OPCODE=0000000: ILLEGAL=1 and PC_WE=1.
- INSTRET preset via 2^32-1 retirements (or a forced value) at 0xFFFFFFFF plus one retire: INSTRET SHALL read 0x00000000.
- RST_N dropped asynchronously in WB: all strobes SHALL be 0 before the next edge, INSTRET=0, and the restart SHALL follow REQ-023.

Source files
------------

// File: rtl/cu_sequencer.sv
// Multi-cycle control-unit sequencer: fetch / execute / write-back / interrupt-entry FSM
// that decodes the opcode into datapath strobes and counts retired instructions.
module cu_sequencer (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [6:0]  OPCODE,
  input  logic [2:0]  FUNC3,
  input  logic        INTR,
  input  logic        MEM_READY,
  output logic        PC_WE,
  output logic        RF_WE,
  output logic        MEM_RDEN1,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic        CSR_WE,
  output logic        INT_TAKEN,
  output logic        MRET_EXEC,
  output logic        ILLEGAL,
  output logic [31:0] INSTRET
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_EXEC,
    S_WB,
    S_INTR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        is_load;
  logic        retire;

  assign is_load = (OPCODE == OP_LOAD);
  // An instruction retires when it leaves EXEC (non-load) or leaves WB (load).
  assign retire  = ((state_q == S_EXEC) && !is_load) || (state_q == S_WB);

  // NOTE: the async reset clears the counter as well as the state, so a
  // half-finished instruction is dropped without ever being counted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_INIT;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q + (retire ? 32'd1 : 32'd0);
    case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: state_d = MEM_READY ? S_EXEC : S_FETCH;
      S_EXEC:  state_d = is_load ? S_WB : (INTR ? S_INTR : S_FETCH);
      S_WB:    state_d = INTR ? S_INTR : S_FETCH;
      S_INTR:  state_d = S_FETCH;
      default: state_d = S_INIT;
    endcase
  end

  // NOTE: every strobe gets a 0 default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    PC_WE     = 1'b0;
    RF_WE     = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;
    ILLEGAL   = 1'b0;
    case (state_q)
      S_FETCH: MEM_RDEN1 = 1'b1;
      S_EXEC: begin
        case (OPCODE)
          OP_LOAD:   MEM_RDEN2 = 1'b1;
          OP_STORE: begin
            MEM_WE2 = 1'b1;
            PC_WE   = 1'b1;
          end
          OP_BRANCH: PC_WE = 1'b1;
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP: begin
            PC_WE = 1'b1;
            RF_WE = 1'b1;
          end
          OP_SYSTEM: begin
            PC_WE = 1'b1;
            case (FUNC3)
              3'b000:                 MRET_EXEC = 1'b1;
              3'b001, 3'b010, 3'b011: begin
                RF_WE  = 1'b1;
                CSR_WE = 1'b1;
              end
              default:                ILLEGAL = 1'b1;
            endcase
          end
          default: begin
            PC_WE   = 1'b1;
            ILLEGAL = 1'b1;
          end
        endcase
      end
      S_WB: begin
        RF_WE = 1'b1;
        PC_WE = 1'b1;
      end
      S_INTR: begin
        INT_TAKEN = 1'b1;
        PC_WE     = 1'b1;
      end
      default: ;
    endcase
  end

  assign INSTRET = instret_q;

endmodule
